// File: rtl/gf_pkg.sv
// Shared types and default sizes for the GF(2^163) divider arbiter.
package gf_pkg;

    localparam int NUM_BITS   = 163;
    localparam int MAX_CYCLES = 1023;
    localparam int CNT_BITS   = 10;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        RESP
    } state_t;

    typedef logic req_id_t;

    // With both requesters asking, the one that was not served last wins.
    function automatic req_id_t rr_pick(input logic r0, input logic r1, input req_id_t last);
        if (r0 && r1) begin
            return ~last;
        end
        return r1;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that wraps at rollover_val; the flag marks the final
// enabled cycle before the wrap, which the arbiter uses as its watchdog timeout.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;
    logic [NUM_CNT_BITS-1:0] last_val;

    assign last_val = rollover_val - NUM_CNT_BITS'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            count <= (count == last_val) ? '0 : count + NUM_CNT_BITS'(1);
        end
    end

    assign rollover_flag = count_enable && (count == last_val);

endmodule

// File: rtl/gf_div_arbiter.sv
// Round-robin arbiter sharing one gf_Div between two requesters, with
// zero-divisor screening and a watchdog on the divider's done signal.
module gf_div_arbiter #(
    parameter int NUM_BITS   = gf_pkg::NUM_BITS,
    parameter int MAX_CYCLES = gf_pkg::MAX_CYCLES,
    parameter int CNT_BITS   = gf_pkg::CNT_BITS
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [NUM_BITS:0] A0,
    input  logic [NUM_BITS:0] A1,
    input  logic [NUM_BITS:0] B0,
    input  logic [NUM_BITS:0] B1,
    output logic              ack0,
    output logic              ack1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [NUM_BITS:0] Q_out,
    output logic              err,
    output logic              busy,
    output logic [NUM_BITS:0] div_A,
    output logic [NUM_BITS:0] div_B,
    output logic              div_start,
    input  logic [NUM_BITS:0] div_Q,
    input  logic              div_done
);
    import gf_pkg::*;

    state_t            state;
    state_t            state_n;
    req_id_t           owner;
    req_id_t           last;
    req_id_t           pick;
    logic [NUM_BITS:0] a_q;
    logic [NUM_BITS:0] b_q;
    logic [NUM_BITS:0] q_reg;
    logic              err_reg;
    logic              timeout;

    assign pick = rr_pick(req0, req1, last);

    flex_counter #(
        .NUM_CNT_BITS (CNT_BITS)
    ) u_watchdog (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state == START),
        .count_enable  (state == WAIT),
        .rollover_val  (CNT_BITS'(MAX_CYCLES)),
        .rollover_flag (timeout)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req0 || req1) state_n = GRANT;
            GRANT:   state_n = (b_q == '0) ? RESP : START;
            START:   state_n = WAIT;
            WAIT:    if (div_done || timeout) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operands are captured on the IDLE->GRANT edge so requesters may change
    // them right after ack; done is checked before timeout so it wins a tie.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            owner   <= 1'b0;
            last    <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            q_reg   <= '0;
            err_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= pick;
                        a_q   <= pick ? A1 : A0;
                        b_q   <= pick ? B1 : B0;
                    end
                end
                GRANT: begin
                    last <= owner;
                    if (b_q == '0) begin
                        q_reg   <= '0;
                        err_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (div_done) begin
                        q_reg   <= div_Q;
                        err_reg <= 1'b0;
                    end else if (timeout) begin
                        q_reg   <= '0;
                        err_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        ack0      = 1'b0;
        ack1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        div_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            GRANT: begin
                ack0 = (owner == 1'b0);
                ack1 = (owner == 1'b1);
            end
            START: div_start = 1'b1;
            RESP: begin
                rvalid0 = (owner == 1'b0);
                rvalid1 = (owner == 1'b1);
            end
            default: begin
            end
        endcase
    end

    assign Q_out = q_reg;
    assign err   = err_reg;
    assign div_A = a_q;
    assign div_B = b_q;

endmodule

// File: tb/tb_gf_div_arbiter.sv
// Scoreboard bench for gf_div_arbiter with a programmable-latency gf_Div stub (Q = A ^ B).
module tb_gf_div_arbiter;

    localparam int NB   = 163;
    localparam int MAXC = 20;

    localparam logic [NB:0] A_SPEC   = {1'b0, 2'b11, 153'b0, 2'b11, 2'b0, 1'b1, 2'b0, 1'b1};
    localparam logic [NB:0] EXP_SPEC = {1'b0, 2'b11, 153'b0, 8'hF5};

    typedef struct {
        bit          id;
        logic [NB:0] q;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        n_rst;
    logic        req0, req1;
    logic [NB:0] A0, A1, B0, B1;
    logic        ack0, ack1, rvalid0, rvalid1;
    logic [NB:0] Q_out;
    logic        err, busy;
    logic [NB:0] div_A, div_B, div_Q;
    logic        div_start, div_done;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   start_cnt = 0;
    int   ack0_cnt  = 0;
    int   ack1_cnt  = 0;

    logic [7:0] stub_lat   = 8'd10;
    logic [7:0] stub_cnt;
    bit         stub_hang  = 1'b0;
    bit         done_force = 1'b0;

    gf_div_arbiter #(
        .NUM_BITS   (NB),
        .MAX_CYCLES (MAXC),
        .CNT_BITS   (10)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .req0      (req0),
        .req1      (req1),
        .A0        (A0),
        .A1        (A1),
        .B0        (B0),
        .B1        (B1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .Q_out     (Q_out),
        .err       (err),
        .busy      (busy),
        .div_A     (div_A),
        .div_B     (div_B),
        .div_start (div_start),
        .div_Q     (div_Q),
        .div_done  (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (div_start) start_cnt <= start_cnt + 1;
        if (ack0) ack0_cnt <= ack0_cnt + 1;
        if (ack1) ack1_cnt <= ack1_cnt + 1;
    end

    // Divider stub: done is sampled exactly stub_lat edges after the start edge.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) stub_cnt <= 8'd0;
        else if (div_start) stub_cnt <= stub_lat;
        else if (stub_cnt != 8'd0) stub_cnt <= stub_cnt - 8'd1;
    end
    assign div_done = ((stub_cnt == 8'd1) && !stub_hang) || done_force;
    assign div_Q    = div_A ^ div_B;

    task automatic check_output(input string name, input logic [NB:0] act, input logic [NB:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (n_rst && (rvalid0 || rvalid1)) begin
            if (sb.size() == 0) begin
                check_int("unexpected_rvalid", 1, 0);
            end else begin
                e = sb.pop_front();
                check_int("rvalid_both", int'(rvalid0 && rvalid1), 0);
                check_int("rvalid_id", int'(rvalid1), int'(e.id));
                check_output("q_out", Q_out, e.q);
                check_int("err", int'(err), int'(e.err));
                check_int("rvalid_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge with the DUT idle; checks ack and start timing.
    task automatic apply_stimulus(input bit id, input logic [NB:0] a, input logic [NB:0] b,
                                  input logic [NB:0] exp_q, input bit exp_err,
                                  input bit exp_start, input int rv_off);
        int n;
        n = cyc;
        if (id) begin
            req1 = 1'b1; A1 = a; B1 = b;
        end else begin
            req0 = 1'b1; A0 = a; B0 = b;
        end
        sb.push_back('{id: id, q: exp_q, err: exp_err, cyc: n + rv_off});
        @(negedge clk);
        check_int(id ? "ack1_k1" : "ack0_k1", int'(id ? ack1 : ack0), 1);
        if (id) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        check_int("start_k2", int'(div_start), int'(exp_start));
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        while (busy && i < max) begin
            @(negedge clk);
            i++;
        end
        check_int("idle_bound", int'(busy), 0);
    endtask

    initial begin
        int s0, r, a0s, a1s;
        bit got;
        n_rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        A0 = '0; A1 = '0; B0 = '0; B1 = '0;
        repeat (2) @(negedge clk);
        check_int("rst_busy", int'(busy), 0);
        check_int("rst_acks", int'({ack0, ack1, rvalid0, rvalid1, div_start, err}), 0);
        check_output("rst_q", Q_out, '0);
        check_output("rst_div_a", div_A, '0);
        n_rst = 1'b1;
        @(negedge clk);

        $display("[TB] single request");
        apply_stimulus(0, A_SPEC, 164'd60, EXP_SPEC, 0, 1, 13);
        wait_idle(50);
        check_output("div_a_held", div_A, A_SPEC);
        check_output("div_b_held", div_B, 164'd60);
        apply_stimulus(1, 164'hF0F0, 164'h0FF0, 164'hFF00, 0, 1, 13);
        wait_idle(50);
        apply_stimulus(0, {1'b1, 163'b0}, 164'd1, {1'b1, 162'b0, 1'b1}, 0, 1, 13);
        wait_idle(50);

        $display("[TB] zero divisor");
        s0 = start_cnt;
        apply_stimulus(1, 164'h1234, '0, '0, 1, 0, 2);
        wait_idle(20);
        check_int("zero_no_start", start_cnt, s0);

        $display("[TB] timeout and done/timeout tie");
        stub_hang = 1'b1;
        apply_stimulus(0, 164'h5, 164'h3, '0, 1, 1, 23);
        wait_idle(60);
        stub_hang = 1'b0;
        stub_lat  = 8'd20;
        apply_stimulus(0, 164'h55, 164'h0F, 164'h5A, 0, 1, 23);
        wait_idle(60);
        stub_lat  = 8'd10;

        $display("[TB] done in idle");
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        repeat (3) @(negedge clk);
        check_int("idle_done_ignored", int'({busy, rvalid0, rvalid1}), 0);

        $display("[TB] re-request during resp");
        apply_stimulus(0, 164'h0A, 164'h03, 164'h09, 0, 1, 13);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = rvalid0;
        end
        check_int("rvalid0_seen", int'(got), 1);
        r = cyc;
        req1 = 1'b1; A1 = 164'hC0; B1 = 164'h0C;
        sb.push_back('{id: 1'b1, q: 164'hCC, err: 1'b0, cyc: r + 14});
        @(negedge clk);
        check_int("rereq_idle_ack", int'({busy, ack1}), 0);
        @(negedge clk);
        check_int("rereq_ack1", int'(ack1), 1);
        req1 = 1'b0;
        wait_idle(50);

        $display("[TB] reset mid-wait");
        apply_stimulus(0, 164'h7, 164'h2, 164'h5, 0, 1, 13);
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        sb.delete();
        #1;
        check_int("midrst_ctl", int'({busy, ack0, ack1, rvalid0, rvalid1, div_start, err}), 0);
        check_output("midrst_q", Q_out, '0);
        check_output("midrst_div_b", div_B, '0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        done_force = 1'b1;
        @(negedge clk);
        done_force = 1'b0;
        repeat (3) @(negedge clk);
        check_int("midrst_late_done", int'({busy, rvalid0, rvalid1}), 0);

        $display("[TB] contention");
        a0s = ack0_cnt; a1s = ack1_cnt;
        A0 = 164'h11; B0 = 164'h22; A1 = 164'h44; B1 = 164'h08;
        req0 = 1'b1; req1 = 1'b1;
        for (int op = 0; op < 4; op++) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                got = ack0 || ack1;
            end
            check_int("grant_seen", int'(got), 1);
            check_int("grant_order", int'(ack1), op % 2);
            check_int("ack_single", int'(ack0 && ack1), 0);
            sb.push_back('{id: ack1, q: ack1 ? 164'h4C : 164'h33, err: 1'b0, cyc: cyc + 12});
            if (op == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clk);
        end
        wait_idle(50);
        check_int("ack0_count", ack0_cnt - a0s, 2);
        check_int("ack1_count", ack1_cnt - a1s, 2);

        repeat (3) @(negedge clk);
        check_int("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL global_timeout actual=expired required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
